// File: rtl/tick_timer_pkg.sv
// Shared types and default widths for the tick timer generator.
package tick_timer_pkg;

   localparam int unsigned DEF_CNT_W      = 24;
   localparam int unsigned DEF_CNT_TICK_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2
   } state_e;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable period down-counter with zero flag; load has priority over decrement.
module tick_down_counter #(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples
   // pre-edge values; the reset is synchronous, so it lives inside the clocked branch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/tick_timer_gen.sv
// Periodic / one-shot tick generator with pause, stop and restart control.
module tick_timer_gen
   import tick_timer_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned CNT_TICK_W = DEF_CNT_TICK_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   input  logic                  one_shot,
   input  logic [CNT_W-1:0]      period,
   input  logic [CNT_TICK_W-1:0] burst_len,
   output logic                  tick,
   output logic [CNT_TICK_W-1:0] tick_index,
   output logic                  busy,
   output logic                  done
);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      period_q, period_d;
   logic                  one_shot_q, one_shot_d;
   logic [CNT_TICK_W-1:0] burst_len_q, burst_len_d;
   logic [CNT_TICK_W-1:0] tick_index_q, tick_index_d;
   logic                  tick_q, tick_d;
   logic                  done_q, done_d;
   logic                  busy_q;

   logic                  cnt_load;
   logic                  cnt_dec;
   logic [CNT_W-1:0]      cnt_load_val;
   logic [CNT_W-1:0]      cnt_value;
   logic                  cnt_zero;

   logic [CNT_W-1:0]      period_eff;
   logic [CNT_TICK_W-1:0] tick_index_inc;

   assign period_eff     = (period == '0) ? CNT_W'(1) : period;
   assign tick_index_inc = tick_index_q + CNT_TICK_W'(1);

   tick_down_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .count_o    (cnt_value),
      .zero_o     (cnt_zero)
   );

   // NOTE: every signal driven here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      period_d     = period_q;
      one_shot_d   = one_shot_q;
      burst_len_d  = burst_len_q;
      tick_index_d = tick_index_q;
      tick_d       = 1'b0;
      done_d       = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = period_q - CNT_W'(1);

      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d      = S_RUN;
               period_d     = period_eff;
               one_shot_d   = one_shot;
               burst_len_d  = burst_len;
               tick_index_d = '0;
               cnt_load     = 1'b1;
               cnt_load_val = period_eff - CNT_W'(1);
            end
         end
         S_RUN, S_PAUSED: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (start) begin
               state_d      = S_RUN;
               period_d     = period_eff;
               one_shot_d   = one_shot;
               burst_len_d  = burst_len;
               tick_index_d = '0;
               cnt_load     = 1'b1;
               cnt_load_val = period_eff - CNT_W'(1);
            end else if (pause) begin
               state_d = S_PAUSED;
            end else begin
               // The edge that releases pause counts, so a pause of N edges delays by N.
               state_d = S_RUN;
               if (cnt_zero) begin
                  tick_d       = 1'b1;
                  tick_index_d = tick_index_inc;
                  cnt_load     = 1'b1;
                  if (one_shot_q && (tick_index_inc == burst_len_q)) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         period_q     <= '0;
         one_shot_q   <= 1'b0;
         burst_len_q  <= '0;
         tick_index_q <= '0;
         tick_q       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         one_shot_q   <= one_shot_d;
         burst_len_q  <= burst_len_d;
         tick_index_q <= tick_index_d;
         tick_q       <= tick_d;
         done_q       <= done_d;
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign tick       = tick_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign tick_index = tick_index_q;

endmodule

// File: tb/tb_tick_timer_gen.sv
// Scoreboard bench: stimulus queues expected tick events, a negedge monitor checks them.
module tb_tick_timer_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, pause, one_shot;
   logic [23:0] period;
   logic [3:0]  burst_len;
   logic        tick, busy, done;
   logic [3:0]  tick_index;

   int unsigned cyc = 0;
   int unsigned tests = 0;
   int unsigned fails = 0;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  idx;
      logic        done;
   } exp_t;

   exp_t sb[$];

   tick_timer_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .one_shot   (one_shot),
      .period     (period),
      .burst_len  (burst_len),
      .tick       (tick),
      .tick_index (tick_index),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // cyc holds the number of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (tick === 1'b1 || done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_event", {tick, done}, 2'b00);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("event_edge", cyc, e.cyc);
            check("event_tick", tick, 1'b1);
            check("event_index", tick_index, e.idx);
            check("event_done", done, e.done);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int unsigned c);
      while (cyc < c) step();
   endtask

   task automatic push(input int unsigned c, input logic [3:0] idx, input logic d);
      exp_t e;
      e.cyc  = c;
      e.idx  = idx;
      e.done = d;
      sb.push_back(e);
   endtask

   task automatic start_run(input logic [23:0] p, input logic os, input logic [3:0] bl,
                            output int unsigned k);
      period    = p;
      one_shot  = os;
      burst_len = bl;
      start     = 1'b1;
      step();
      start     = 1'b0;
      k         = cyc;
   endtask

   task automatic stop_at(input int unsigned e);
      wait_to(e - 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k;
      rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; one_shot = 1'b0;
      period = '0; burst_len = '0;
      repeat (3) step();
      check("rst_tick", tick, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_index", tick_index, 4'd0);
      rst = 1'b1;
      repeat (2) step();

      // Periodic, period 5: ticks 5, 10, 15 edges after start.
      start_run(24'd5, 1'b0, 4'd0, k);
      push(k + 5, 4'd1, 1'b0);
      push(k + 10, 4'd2, 1'b0);
      push(k + 15, 4'd3, 1'b0);
      wait_to(k + 7);
      check("p5_busy_run", busy, 1'b1);
      stop_at(k + 18);
      check("p5_busy_stopped", busy, 1'b0);
      check("p5_index_held", tick_index, 4'd3);
      repeat (6) step();

      // One-shot, period 0 (acts as 1), burst 3.
      start_run(24'd0, 1'b1, 4'd3, k);
      push(k + 1, 4'd1, 1'b0);
      push(k + 2, 4'd2, 1'b0);
      push(k + 3, 4'd3, 1'b1);
      wait_to(k + 2);
      check("os3_busy_run", busy, 1'b1);
      wait_to(k + 4);
      check("os3_busy_after", busy, 1'b0);
      check("os3_done_after", done, 1'b0);
      repeat (4) step();

      // One-shot with burst_len 0 runs 16 ticks.
      start_run(24'd1, 1'b1, 4'd0, k);
      for (int i = 1; i <= 16; i++) push(k + i, 4'(i), (i == 16));
      wait_to(k + 20);
      check("os16_busy_after", busy, 1'b0);

      // Period 4 paused for 6 edges after 2 counts: first tick moves from +4 to +10.
      start_run(24'd4, 1'b0, 4'd0, k);
      push(k + 10, 4'd1, 1'b0);
      push(k + 14, 4'd2, 1'b0);
      wait_to(k + 2);
      pause = 1'b1;
      wait_to(k + 5);
      check("pause_busy", busy, 1'b1);
      check("pause_index", tick_index, 4'd0);
      wait_to(k + 8);
      pause = 1'b0;
      stop_at(k + 15);
      repeat (4) step();

      // Period 3, start and stop together in RUN: stop wins.
      start_run(24'd3, 1'b0, 4'd0, k);
      push(k + 3, 4'd1, 1'b0);
      push(k + 6, 4'd2, 1'b0);
      wait_to(k + 6);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("ss_busy", busy, 1'b0);
      check("ss_index", tick_index, 4'd2);
      repeat (10) step();

      // Mid-run config changes are ignored until a restart relatches them.
      start_run(24'd3, 1'b0, 4'd0, k);
      push(k + 3, 4'd1, 1'b0);
      push(k + 6, 4'd2, 1'b0);
      push(k + 14, 4'd1, 1'b0);
      push(k + 21, 4'd2, 1'b1);
      wait_to(k + 3);
      period    = 24'd7;
      one_shot  = 1'b1;
      burst_len = 4'd2;
      wait_to(k + 6);
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_index", tick_index, 4'd0);
      check("restart_busy", busy, 1'b1);
      wait_to(k + 23);
      check("restart_os_busy", busy, 1'b0);

      // Period 1 periodic: 17 ticks wrap the index 15 -> 0 -> 1.
      start_run(24'd1, 1'b0, 4'd0, k);
      for (int i = 1; i <= 17; i++) push(k + i, 4'(i), 1'b0);
      stop_at(k + 18);
      check("wrap_index", tick_index, 4'd1);
      repeat (3) step();

      // Reset mid-run with period 2 discards the pending tick.
      start_run(24'd2, 1'b0, 4'd0, k);
      push(k + 2, 4'd1, 1'b0);
      push(k + 4, 4'd2, 1'b0);
      wait_to(k + 4);
      rst = 1'b0;
      step();
      check("mrst_tick", tick, 1'b0);
      check("mrst_done", done, 1'b0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_index", tick_index, 4'd0);
      rst = 1'b1;
      repeat (8) step();
      check("mrst_idle_busy", busy, 1'b0);
      start_run(24'd2, 1'b0, 4'd0, k);
      push(k + 2, 4'd1, 1'b0);
      stop_at(k + 3);
      repeat (4) step();

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
